seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, blanking included; legal range >= 2.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500: all-off cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 The block SHALL have port i_clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_value, input, width 16: four hex nibbles; digit0 = [3:0], digit3 = [15:12].
REQ-006 The block SHALL have port i_dp, input, width 4: decimal point per digit; bit n = digit n; 1 = lit.
REQ-007 The block SHALL have port i_blank_lz, input, width 1: leading-zero suppression enable.
REQ-008 The block SHALL have port i_load, input, width 1: update request, sampled every cycle.
REQ-009 The block SHALL have port o_load_ack, output, width 1: one-cycle pulse when pending data becomes active.
REQ-010 The block SHALL have port o_digitSelect, output, width 4: digit enables, active-low; bit n = digit n.
REQ-011 The block SHALL have port o_seg, output, width 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-012 The block SHALL have port o_dp, output, width 1: decimal point segment, active-low.
REQ-013 The block SHALL have port o_frame, output, width 1: one-cycle pulse at each frame start.

Function
REQ-014 The block SHALL register all outputs; no combinational path from any input to any output.
REQ-015 The slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit index 0..3 increments modulo 4.
REQ-016 The block SHALL implement two states per slot: BLANK while slot count < BLANK_CYCLES, SHOW otherwise.
REQ-017 In BLANK (anti-ghosting), outputs SHALL be o_digitSelect=4'b1111, o_seg=7'b1111111, o_dp=1.
REQ-018 In SHOW, o_digitSelect SHALL drive only the active digit low: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
REQ-019 In SHOW, o_seg SHALL show the hex decode of the active nibble, for example: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-020 In SHOW, o_dp SHALL be the inverse of the active dp bit.
REQ-021 Output registers SHALL update one cycle after the counter/index state they reflect; this one-cycle latency is fixed.
REQ-022 If the index/slot state implies an undefined digit, outputs SHALL take the BLANK values.
REQ-023 Leading-zero suppression: when active blank_lz=1, digit n (n=3..1) SHALL be blanked (o_seg all 1) if its nibble and all higher nibbles are 0.
REQ-024 Digit 0 SHALL never be suppressed, and dp SHALL still be honoured on suppressed digits.
REQ-025 Active data (value, dp, blank_lz) SHALL change only at a frame boundary: the cycle where the index wraps 3->0.
REQ-026 i_load=1 SHALL capture i_value, i_dp and i_blank_lz into a pending register and set the pending flag.
REQ-027 A later i_load while pending SHALL overwrite the pending data (latest wins); no ack is issued for the overwritten data.
REQ-028 At a frame boundary with pending set, the block SHALL copy pending to active, clear pending, and pulse o_load_ack.
REQ-029 o_load_ack SHALL be aligned with o_frame.
REQ-030 If i_load coincides with a commit cycle, the old pending data SHALL be committed, the new data captured, and pending remain 1.
REQ-031 If i_load arrives at a boundary with no prior pending data, it SHALL commit at the next boundary.
REQ-032 o_frame SHALL pulse for exactly one cycle, in the first output cycle of digit 0's slot.
REQ-033 Frame period SHALL be 4*SCAN_DIV cycles.

Reset
REQ-034 While i_rst=0, asynchronously: slot count=0, index=0, active and pending data=0, pending flag=0.
REQ-035 While i_rst=0: o_digitSelect=1111, o_seg=1111111, o_dp=1, o_frame=0, o_load_ack=0.
REQ-036 Reset mid-frame or mid-load SHALL discard pending data with no ack.
REQ-037 After release, the first slot SHALL be digit 0; no o_frame pulse for that first frame.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-038 Reset release, no load -> digit0 slot: 2 cycles 1111/1111111, then 6 cycles 1110/1000000, then digit1 slot; o_frame first pulses at cycle 32.
REQ-039 Load 16'h8A10, dp=4'b0100 mid-frame -> no change until the boundary; then o_load_ack=o_frame=1 and digits show 0,1,A,8; the digit2 slot has o_dp=0.
REQ-040 Load 16'h0001, blank_lz=1 -> digits 3..1 o_seg=1111111 while lit (selects low); digit0 shows 1111001.
REQ-041 Two loads (16'h1111 then 16'h2222) within one frame -> one ack; the display shows 2222 only.
REQ-042 Load asserted exactly on the commit cycle -> previous data committed with ack; the new data commits with a second ack one frame (32 cycles) later.
REQ-043 Reset asserted with pending set mid-slot -> outputs blank immediately; after release, active data=0 and no ack.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Blanks each slot, suppresses leading zeros, commits new data per frame.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_value[15:0]  four hex nibbles, digit0 = [3:0]
//   i_dp[3:0]      decimal point per digit, 1 = lit
//   i_blank_lz     leading-zero suppression enable
//   i_load         capture value/dp/blank_lz into pending
//   o_load_ack     pulse when pending data becomes active
//   o_digitSelect  digit enables, active low
//   o_seg          segments {g,f,e,d,c,b,a}, active low
//   o_dp           decimal point segment, active low
//   o_frame        pulse at each frame start
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  input  logic        i_load,
  output logic        o_load_ack,
  output logic [3:0]  o_digitSelect,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] SLOT_LAST =
    CW'(SCAN_DIV - 1);

  localparam logic [CW-1:0] BLANK_N =
    CW'(BLANK_CYCLES);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
  } disp_t;

  typedef enum logic [0:0] {
    ST_BLANK,
    ST_SHOW
  } state_t;

  localparam state_t ST_RST =
    (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  // Scan position and slot phase
  logic [CW-1:0] slot_q;
  logic [CW-1:0] slot_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  state_t        state_q;
  state_t        state_d;

  // Data path
  disp_t act_q;
  disp_t pend_q;
  logic  pend_vld_q;
  logic  commit_q;
  logic  started_q;

  // Combinational decode
  logic       last_slot;
  logic       wrap;
  logic [3:0] nib;
  logic [3:0] lz_sup;
  logic [3:0] sel_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic       frame_d;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next scan position and slot phase
  always_comb begin
    last_slot = (slot_q == SLOT_LAST);
    wrap      = last_slot && (idx_q == 2'd3);
    slot_d    = last_slot ? '0 : slot_q + CW'(1);
    idx_d     = last_slot ? idx_q + 2'd1 : idx_q;
    state_d   = (slot_d < BLANK_N) ? ST_BLANK
                                   : ST_SHOW;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      slot_q  <= '0;
      idx_q   <= '0;
      state_q <= ST_RST;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Active nibble of the current slot
  always_comb begin
    nib = 4'h0;
    unique case (idx_q)
      2'd0: nib = act_q.value[3:0];
      2'd1: nib = act_q.value[7:4];
      2'd2: nib = act_q.value[11:8];
      2'd3: nib = act_q.value[15:12];
      default: nib = 4'h0;
    endcase
  end

  // A digit is suppressed only if it and every
  // higher digit are zero; digit 0 always shows.
  always_comb begin
    lz_sup    = 4'b0000;
    lz_sup[3] = act_q.lz &&
                (act_q.value[15:12] == 4'h0);
    lz_sup[2] = lz_sup[3] &&
                (act_q.value[11:8] == 4'h0);
    lz_sup[1] = lz_sup[2] &&
                (act_q.value[7:4] == 4'h0);
  end

  // Output decode; anything but SHOW is blank
  always_comb begin
    sel_d   = 4'b1111;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    frame_d = started_q &&
              (slot_q == '0) &&
              (idx_q == 2'd0);
    unique case (state_q)
      ST_SHOW: begin
        sel_d = ~(4'b0001 << idx_q);
        seg_d = lz_sup[idx_q] ? 7'h7F
                              : hex7(nib);
        dp_d  = ~act_q.dp[idx_q];
      end
      default: begin
        sel_d = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_digitSelect <= 4'b1111;
      o_seg         <= 7'h7F;
      o_dp          <= 1'b1;
      o_frame       <= 1'b0;
      o_load_ack    <= 1'b0;
    end else begin
      o_digitSelect <= sel_d;
      o_seg         <= seg_d;
      o_dp          <= dp_d;
      o_frame       <= frame_d;
      // commit_q is set on the wrap edge, so the
      // ack lands with the frame pulse.
      o_load_ack    <= commit_q;
    end
  end

  // Pending / active data; a load on the commit
  // edge refills pending after the old data moves.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      commit_q   <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      commit_q <= wrap && pend_vld_q;
      if (wrap) begin
        started_q <= 1'b1;
      end
      if (wrap && pend_vld_q) begin
        act_q <= pend_q;
      end
      if (i_load) begin
        pend_q     <= '{value: i_value,
                        dp:    i_dp,
                        lz:    i_blank_lz};
        pend_vld_q <= 1'b1;
      end else if (wrap) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl.
// SCAN_DIV=8, BLANK_CYCLES=2; frame = 32 cycles.
module tb_seg_scan_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic        i_load;
  logic        o_load_ack;
  logic [3:0]  o_digitSelect;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  int checks;
  int errors;
  int e;

  seg_scan_ctrl #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_value       (i_value),
    .i_dp          (i_dp),
    .i_blank_lz    (i_blank_lz),
    .i_load        (i_load),
    .o_load_ack    (o_load_ack),
    .o_digitSelect (o_digitSelect),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame       (o_frame)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Edges since reset release
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) e <= 0;
    else        e <= e + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic go(input int k);
    int n;
    n = 0;
    while (e < k && n < 400) begin
      step();
      n++;
    end
    if (e != k) chk("goto", 16'(e), 16'(k));
  endtask

  task automatic disp(
    input string      tag,
    input logic [3:0] sel,
    input logic [6:0] seg,
    input logic       dp
  );
    chk({tag, "_sel"}, 16'(o_digitSelect), 16'(sel));
    chk({tag, "_seg"}, 16'(o_seg), 16'(seg));
    chk({tag, "_dp"},  16'(o_dp), 16'(dp));
  endtask

  task automatic load(
    input logic [15:0] v,
    input logic [3:0]  d,
    input logic        lz
  );
    i_value    = v;
    i_dp       = d;
    i_blank_lz = lz;
    i_load     = 1'b1;
    step();
    i_load     = 1'b0;
  endtask

  initial begin
    int f;
    checks     = 0;
    errors     = 0;
    i_rst      = 1'b0;
    i_value    = '0;
    i_dp       = '0;
    i_blank_lz = 1'b0;
    i_load     = 1'b0;
    repeat (3) step();

    // Reset state
    disp("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst_frame", 16'(o_frame), 16'h0);
    chk("rst_ack", 16'(o_load_ack), 16'h0);
    i_rst = 1'b1;

    // Idle scan after release
    go(1);
    disp("d0_blank_a", 4'hF, 7'h7F, 1'b1);
    chk("no_frame_1", 16'(o_frame), 16'h0);
    go(2);
    disp("d0_blank_b", 4'hF, 7'h7F, 1'b1);
    go(3);
    disp("d0_show", 4'hE, 7'h40, 1'b1);
    go(8);
    disp("d0_last", 4'hE, 7'h40, 1'b1);
    go(9);
    disp("d1_blank", 4'hF, 7'h7F, 1'b1);
    go(11);
    disp("d1_show", 4'hD, 7'h40, 1'b1);

    f = -1;
    for (int i = 0; i < 40; i++) begin
      if (o_frame === 1'b1) begin
        f = e;
        break;
      end
      step();
    end
    chk("first_frame", 16'(f), 16'd33);
    chk("idle_ack", 16'(o_load_ack), 16'h0);
    step();
    chk("frame_1cyc", 16'(o_frame), 16'h0);

    // Mid-frame load waits for boundary
    go(34);
    load(16'h8A10, 4'b0100, 1'b0);
    go(43);
    disp("held_d1", 4'hD, 7'h40, 1'b1);
    go(59);
    disp("held_d3", 4'h7, 7'h40, 1'b1);
    go(65);
    chk("ld_frame", 16'(o_frame), 16'h1);
    chk("ld_ack", 16'(o_load_ack), 16'h1);
    go(66);
    chk("ack_1cyc", 16'(o_load_ack), 16'h0);
    go(67);
    disp("v_d0", 4'hE, 7'h40, 1'b1);
    go(75);
    disp("v_d1", 4'hD, 7'h79, 1'b1);
    go(83);
    disp("v_d2", 4'hB, 7'h08, 1'b0);
    go(91);
    disp("v_d3", 4'h7, 7'h00, 1'b1);

    // Leading-zero suppression
    load(16'h0001, 4'b0000, 1'b1);
    go(97);
    chk("lz_ack", 16'(o_load_ack), 16'h1);
    go(99);
    disp("lz_d0", 4'hE, 7'h79, 1'b1);
    go(107);
    disp("lz_d1", 4'hD, 7'h7F, 1'b1);
    go(115);
    disp("lz_d2", 4'hB, 7'h7F, 1'b1);
    go(123);
    disp("lz_d3", 4'h7, 7'h7F, 1'b1);

    // Two loads in one frame: latest wins
    load(16'h1111, 4'b0000, 1'b0);
    go(125);
    load(16'h2222, 4'b0000, 1'b0);
    go(129);
    chk("ow_ack", 16'(o_load_ack), 16'h1);
    go(131);
    disp("ow_d0", 4'hE, 7'h24, 1'b1);
    go(139);
    disp("ow_d1", 4'hD, 7'h24, 1'b1);
    go(155);
    disp("ow_d3", 4'h7, 7'h24, 1'b1);
    go(161);
    chk("ow_frame2", 16'(o_frame), 16'h1);
    chk("ow_no_ack2", 16'(o_load_ack), 16'h0);

    // Load on the commit edge
    go(165);
    load(16'h3333, 4'b0000, 1'b0);
    go(191);
    load(16'h4444, 4'b0000, 1'b0);
    go(193);
    chk("cc_frame", 16'(o_frame), 16'h1);
    chk("cc_ack1", 16'(o_load_ack), 16'h1);
    go(195);
    disp("cc_d0_old", 4'hE, 7'h30, 1'b1);
    go(225);
    chk("cc_ack2", 16'(o_load_ack), 16'h1);
    go(227);
    disp("cc_d0_new", 4'hE, 7'h19, 1'b1);

    // Reset with pending data
    go(230);
    load(16'h5555, 4'b0000, 1'b0);
    go(236);
    disp("pre_rst", 4'hD, 7'h19, 1'b1);
    #2;
    i_rst = 1'b0;
    #1;
    disp("async_rst", 4'hF, 7'h7F, 1'b1);
    chk("rst_ack2", 16'(o_load_ack), 16'h0);
    step();
    step();
    i_rst = 1'b1;
    go(3);
    disp("post_d0", 4'hE, 7'h40, 1'b1);
    go(11);
    disp("post_d1", 4'hD, 7'h40, 1'b1);
    go(33);
    chk("post_frame", 16'(o_frame), 16'h1);
    chk("post_no_ack", 16'(o_load_ack), 16'h0);
    go(35);
    disp("post_d0b", 4'hE, 7'h40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
